// File: rtl/glitc_disperse_inject.sv
// rtl/glitc_disperse_inject.sv - injects a stored 64-sample dispersed pulse offset onto a 16-sample/clk stream
module glitc_disperse_inject #(
    parameter int TRIG_DELAY = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [47:0] raw_i,
    output logic [47:0] disp_o,
    input  logic        trig_i,
    input  logic        wr_en_i,
    input  logic [5:0]  wr_addr_i,
    input  logic [2:0]  wr_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        trig_drop_o,
    output logic        wr_err_o
);

    typedef enum logic [1:0] {IDLE, ARM, PLAY, DONE} state_t;

    state_t      state;
    logic [1:0]  frame;
    logic [3:0]  dcnt;
    logic [2:0]  tbl [64];
    logic [47:0] play_data;

    // Signed 5-bit sum spans -4..10; bit 4 flags negative, bit 3 flags >7.
    for (genvar g = 0; g < 16; g++) begin : g_sample
        logic [2:0] ofs;
        logic [4:0] sum;
        assign ofs = tbl[{frame, 4'(g)}];
        assign sum = {2'b00, raw_i[3*g +: 3]} + {{2{ofs[2]}}, ofs};
        assign play_data[3*g +: 3] = sum[4] ? 3'd0 :
                                     sum[3] ? 3'd7 : sum[2:0];
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            frame       <= 2'd0;
            dcnt        <= 4'd0;
            disp_o      <= 48'd0;
            trig_drop_o <= 1'b0;
            wr_err_o    <= 1'b0;
            for (int n = 0; n < 64; n++) tbl[n] <= 3'd0;
        end else begin
            disp_o      <= (state == PLAY) ? play_data : raw_i;
            trig_drop_o <= trig_i  && (state != IDLE);
            wr_err_o    <= wr_en_i && (state != IDLE);
            case (state)
                IDLE: begin
                    // Write lands at this edge, so a same-cycle trigger plays the new value.
                    if (wr_en_i) tbl[wr_addr_i] <= wr_data_i;
                    if (trig_i) begin
                        frame <= 2'd0;
                        dcnt  <= 4'd0;
                        state <= (TRIG_DELAY > 0) ? ARM : PLAY;
                    end
                end
                ARM: begin
                    if (dcnt == 4'(TRIG_DELAY - 1)) begin
                        dcnt  <= 4'd0;
                        state <= PLAY;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                PLAY: begin
                    if (frame == 2'd3) begin
                        frame <= 2'd0;
                        state <= DONE;
                    end else begin
                        frame <= frame + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
